alu_serial_n: RTL



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_digit4.sv | 27 ++
 rtl/alu_serial_n.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the digit-serial 74181-style ALU.
package alu_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  localparam logic [3:0] SEL_ADD    = 4'b1001;
  localparam logic [3:0] SEL_SUB    = 4'b0110;
  localparam logic [3:0] SEL_XOR    = 4'b0110;
  localparam logic [3:0] SEL_PASS_A = 4'b1111;

endpackage

// File: rtl/alu_digit4.sv
// Combinational active-high 74181-equivalent 4-bit slice with carry into bit 3 exposed.
module alu_digit4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sel,
  input  logic       mode,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout,
  output logic       c3
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  // Every function is X + Y (+cin) in arithmetic mode and ~(X ^ Y) in logic mode.
  always_comb begin
    x    = a | (b & {4{sel[0]}}) | (~b & {4{sel[1]}});
    y    = (a & ~b & {4{sel[2]}}) | (a & b & {4{sel[3]}});
    sum  = {1'b0, x} + {1'b0, y} + {4'b0000, cin & ~mode};
    f    = mode ? ~(x ^ y) : sum[3:0];
    cout = sum[4] & ~mode;
    c3   = (sum[3] ^ x[3] ^ y[3]) & ~mode;
  end

endmodule

// File: rtl/alu_serial_n.sv
// Digit-serial WIDTH-bit 74181-style ALU with valid/ready handshakes, zero and overflow flags.
// Optional macro ALU_LOGIC_BYPASS_EN computes logic-mode operations in one cycle.
module alu_serial_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int IDX_W  = $clog2(DIGITS);

  alu_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [3:0]       sel_reg;
  logic             mode_reg, carry_reg, cout_reg, zero_reg, ovf_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             last_digit;
  logic [3:0]       dig_f;
  logic             dig_cout, dig_c3;
  logic [WIDTH-1:0] serial_next;

  assign last_digit  = (idx_reg == IDX_W'(DIGITS - 1));
  assign serial_next = {dig_f, result_reg[WIDTH-1:DIGIT_W]};

  // Operands shift right each digit, so the slice always sees the low digit.
  alu_digit4 u_digit (
    .a    (a_reg[DIGIT_W-1:0]),
    .b    (b_reg[DIGIT_W-1:0]),
    .sel  (sel_reg),
    .mode (mode_reg),
    .cin  (carry_reg),
    .f    (dig_f),
    .cout (dig_cout),
    .c3   (dig_c3)
  );

`ifdef ALU_LOGIC_BYPASS_EN
  logic [WIDTH-1:0]  bp_f;
  logic [DIGITS-1:0] bp_cout, bp_c3;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bypass
      alu_digit4 u_bp (
        .a    (a_reg[gi*DIGIT_W +: DIGIT_W]),
        .b    (b_reg[gi*DIGIT_W +: DIGIT_W]),
        .sel  (sel_reg),
        .mode (1'b1),
        .cin  (1'b0),
        .f    (bp_f[gi*DIGIT_W +: DIGIT_W]),
        .cout (bp_cout[gi]),
        .c3   (bp_c3[gi])
      );
    end
  endgenerate
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
`ifdef ALU_LOGIC_BYPASS_EN
        if (mode_reg || last_digit) state_next = DONE;
`else
        if (last_digit) state_next = DONE;
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sel_reg    <= '0;
      mode_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      idx_reg    <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            sel_reg   <= sel;
            mode_reg  <= mode;
            carry_reg <= cin & ~mode;
            idx_reg   <= '0;
          end
        end
        RUN: begin
`ifdef ALU_LOGIC_BYPASS_EN
          if (mode_reg) begin
            result_reg <= bp_f;
            zero_reg   <= (bp_f == '0);
            cout_reg   <= |bp_cout;
            ovf_reg    <= |bp_c3;
          end else
`endif
          begin
            result_reg <= serial_next;
            a_reg      <= a_reg >> DIGIT_W;
            b_reg      <= b_reg >> DIGIT_W;
            carry_reg  <= dig_cout;
            idx_reg    <= idx_reg + IDX_W'(1);
            if (last_digit) begin
              cout_reg <= dig_cout;
              ovf_reg  <= dig_c3 ^ dig_cout;
              zero_reg <= (serial_next == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign cout   = cout_reg;
  assign zero   = zero_reg;
  assign ovf    = ovf_reg;

endmodule
